// File: rtl/key_pkg.sv
// Shared definitions for the key handling path: FSM state encoding and the
// default timing constants at the 50 MHz system clock.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } key_state_t;

    // 1 s long-press threshold and 300 ms double-click window at 50 MHz
    localparam int KEY_LONG_TIME  = 50_000_000;
    localparam int KEY_DCLICK_GAP = 15_000_000;

endpackage : key_pkg

// File: rtl/key_event_decoder.sv
// Turns the debounced active-low key level into single-click, double-click
// and long-press pulses, plus a level that stays high while a long press is
// held.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | key released, waiting for a fresh press edge
// PRESS1    | first press in progress, counting towards long press
// WAIT2     | first press released, counting the double-click window
// PRESS2    | second press in progress, double click emitted on release
// LONG_HOLD | long press reported, waiting for release (hold = 1)
module key_event_decoder
    import key_pkg::*;
#(
    parameter int LONG_TIME  = KEY_LONG_TIME,
    parameter int DCLICK_GAP = KEY_DCLICK_GAP
) (
    input  logic clk,
    input  logic rst_n,
    input  logic click_n,
    output logic single_p,
    output logic double_p,
    output logic long_p,
    output logic hold
);

    localparam int CNT_MAX = (LONG_TIME > DCLICK_GAP) ? LONG_TIME : DCLICK_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(DCLICK_GAP - 1);

    localparam logic [2:0] ST_IDLE      = IDLE;
    localparam logic [2:0] ST_PRESS1    = PRESS1;
    localparam logic [2:0] ST_WAIT2     = WAIT2;
    localparam logic [2:0] ST_PRESS2    = PRESS2;
    localparam logic [2:0] ST_LONG_HOLD = LONG_HOLD;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_click_d;
    logic             r_single_p;
    logic             r_double_p;
    logic             r_long_p;
    logic             r_hold;
    logic             w_press_edge;

    // Reset value 0 means a key held through reset never looks like a new press
    assign w_press_edge = r_click_d & ~click_n;

    // Delayed key level for press-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_click_d <= 1'b0;
        end else begin
            r_click_d <= click_n;
        end
    end

    // Event FSM with the shared down-window counter; release/press on a
    // terminal-count cycle takes priority over the timeout event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_single_p <= 1'b0;
            r_double_p <= 1'b0;
            r_long_p   <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            r_single_p <= 1'b0;
            r_double_p <= 1'b0;
            r_long_p   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_hold <= 1'b0;
                    if (w_press_edge) begin
                        r_state <= ST_PRESS1;
                        r_cnt   <= '0;
                    end
                end
                ST_PRESS1: begin
                    if (click_n) begin
                        r_state <= ST_WAIT2;
                        r_cnt   <= '0;
                    end else if (r_cnt == LONG_TC) begin
                        r_long_p <= 1'b1;
                        r_hold   <= 1'b1;
                        r_state  <= ST_LONG_HOLD;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT2: begin
                    if (!click_n) begin
                        r_state <= ST_PRESS2;
                        r_cnt   <= '0;
                    end else if (r_cnt == GAP_TC) begin
                        r_single_p <= 1'b1;
                        r_state    <= ST_IDLE;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_PRESS2: begin
                    if (click_n) begin
                        r_double_p <= 1'b1;
                        r_state    <= ST_IDLE;
                        r_cnt      <= '0;
                    end
                end
                ST_LONG_HOLD: begin
                    if (click_n) begin
                        r_hold  <= 1'b0;
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_hold  <= 1'b0;
                end
            endcase
        end
    end

    assign single_p = r_single_p;
    assign double_p = r_double_p;
    assign long_p   = r_long_p;
    assign hold     = r_hold;

endmodule : key_event_decoder

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with LONG_TIME=20, DCLICK_GAP=10.
module tb_key_event_decoder;

    localparam int LT = 20;
    localparam int DG = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic click_n = 1'b0;
    logic single_p, double_p, long_p, hold;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int n_single, n_double, n_long, n_hold, n_multi;
    int last_single, last_double, last_long;
    int p0, r0;

    key_event_decoder #(.LONG_TIME(LT), .DCLICK_GAP(DG)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .click_n  (click_n),
        .single_p (single_p),
        .double_p (double_p),
        .long_p   (long_p),
        .hold     (hold)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        n_single = 0; n_double = 0; n_long = 0; n_hold = 0; n_multi = 0;
        last_single = -1; last_double = -1; last_long = -1;
    endtask

    // One clock edge; outputs sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (single_p) begin n_single++; last_single = cyc; end
        if (double_p) begin n_double++; last_double = cyc; end
        if (long_p)   begin n_long++;   last_long   = cyc; end
        if (hold)     n_hold++;
        if (int'(single_p) + int'(double_p) + int'(long_p) > 1) n_multi++;
    endtask

    task automatic press(input int n);
        click_n = 1'b0;
        repeat (n) tick();
    endtask

    task automatic release_key(input int n);
        click_n = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        clr_counts();

        // reset with the key held down
        rst_n = 1'b0;
        click_n = 1'b0;
        repeat (3) tick();
        check_val("rst_single", int'(single_p), 0);
        check_val("rst_double", int'(double_p), 0);
        check_val("rst_long",   int'(long_p),   0);
        check_val("rst_hold",   int'(hold),     0);
        rst_n = 1'b1;
        clr_counts();
        press(30);
        release_key(15);
        check_val("held_thru_rst_pulses", n_single + n_double + n_long, 0);
        check_val("held_thru_rst_hold", n_hold, 0);

        // single click
        clr_counts();
        press(5);
        r0 = cyc + 1;
        release_key(15);
        check_val("single_cnt", n_single, 1);
        check_val("single_time", last_single, r0 + DG);
        check_val("single_other", n_double + n_long, 0);

        // double click, then a third press starts a new single
        clr_counts();
        press(5);
        release_key(4);
        press(3);
        release_key(1);
        check_val("double_time", last_double, cyc);
        release_key(15);
        check_val("double_cnt", n_double, 1);
        check_val("double_no_single", n_single, 0);
        clr_counts();
        press(3);
        r0 = cyc + 1;
        release_key(15);
        check_val("third_press_single", last_single, r0 + DG);

        // long press
        clr_counts();
        p0 = cyc + 1;
        press(40);
        check_val("long_time", last_long, p0 + LT);
        check_val("long_hold_level", int'(hold), 1);
        release_key(15);
        check_val("long_cnt", n_long, 1);
        check_val("long_hold_cycles", n_hold, 40 - LT);
        check_val("long_no_click", n_single + n_double, 0);
        check_val("long_hold_released", int'(hold), 0);

        // release on PRESS1 terminal count
        clr_counts();
        press(LT);
        r0 = cyc + 1;
        release_key(15);
        check_val("tc_release_no_long", n_long, 0);
        check_val("tc_release_single", last_single, r0 + DG);

        // press on WAIT2 terminal count
        clr_counts();
        press(3);
        release_key(DG);
        press(3);
        release_key(1);
        check_val("tc_press_double", last_double, cyc);
        release_key(15);
        check_val("tc_press_no_single", n_single, 0);
        check_val("tc_press_double_cnt", n_double, 1);

        // reset mid-WAIT2
        clr_counts();
        press(5);
        release_key(5);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_wait2_outs", int'(single_p | double_p | long_p | hold), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        release_key(20);
        check_val("rst_wait2_no_single", n_single, 0);

        // reset mid-LONG_HOLD
        clr_counts();
        press(LT + 5);
        check_val("pre_rst_hold", int'(hold), 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_long_hold_async", int'(hold), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        clr_counts();
        press(30);
        release_key(15);
        check_val("rst_long_no_hold", n_hold, 0);
        check_val("rst_long_no_pulse", n_single + n_double + n_long, 0);
        check_val("one_hot_pulses", n_multi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_key_event_decoder
